// File: rtl/packet_slot_tracker.sv
// Tracks outbound packet slots from acceptance through transmission to ACK/NACK.
// Keeps per-slot payloads and a FIFO of slot indices awaiting (re)transmission.
module packet_slot_tracker #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned DATA_WIDTH  = 64
) (
  input  logic                          nocclk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          free_index_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] free_index,
  output logic                          free_index_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_ENTRIES)-1:0] out_index,
  input  logic                          ack_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] ack_index,
  input  logic                          nack_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] nack_index,
  output logic                          return_index_valid,
  output logic [$clog2(NUM_ENTRIES)-1:0] return_index,
  output logic [$clog2(NUM_ENTRIES):0]  outstanding_count,
  output logic                          protocol_error
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    SLOT_EMPTY    = 2'd0,
    SLOT_PENDING  = 2'd1,
    SLOT_WAIT_ACK = 2'd2
  } slot_state_t;

  slot_state_t           slot_state [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] payload    [NUM_ENTRIES];
  logic [IDX_W-1:0]      queue_mem  [NUM_ENTRIES];
  logic [IDX_W-1:0]      head;
  logic [IDX_W-1:0]      tail;
  logic [CNT_W-1:0]      q_count;

  logic             same_idx;
  logic             ack_ok;
  logic             ack_err;
  logic             nack_accept;
  logic             nack_err;
  logic             accept;
  logic             accept_err;
  logic             send;
  logic             push;
  logic [IDX_W-1:0] push_idx;

  // Event decode; a NACK owns the single enqueue port so it blocks new input.
  always_comb begin
    same_idx    = 1'b0;
    ack_ok      = 1'b0;
    ack_err     = 1'b0;
    nack_accept = 1'b0;
    nack_err    = 1'b0;
    accept      = 1'b0;
    accept_err  = 1'b0;
    send        = 1'b0;
    push        = 1'b0;
    push_idx    = free_index;

    same_idx    = ack_valid && (ack_index == nack_index);
    ack_ok      = ack_valid && (slot_state[ack_index] == SLOT_WAIT_ACK);
    ack_err     = ack_valid && !ack_ok;
    nack_accept = nack_valid && !same_idx && (slot_state[nack_index] == SLOT_WAIT_ACK);
    nack_err    = nack_valid && !same_idx && (slot_state[nack_index] != SLOT_WAIT_ACK);
    accept      = in_valid && free_index_valid && !nack_accept;
    accept_err  = accept && (slot_state[free_index] != SLOT_EMPTY);
    send        = (q_count != '0) && out_ready;
    push        = accept || nack_accept;
    if (nack_accept) begin
      push_idx = nack_index;
    end
  end

  assign in_ready         = free_index_valid && !nack_accept;
  assign free_index_ready = accept;
  assign out_valid        = (q_count != '0);
  assign out_index        = queue_mem[head];
  assign out_data         = payload[queue_mem[head]];

  // Slot lifecycle, send-queue pointers and status registers.
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        slot_state[i] <= SLOT_EMPTY;
      end
      head               <= '0;
      tail               <= '0;
      q_count            <= '0;
      return_index_valid <= 1'b0;
      return_index       <= '0;
      outstanding_count  <= '0;
      protocol_error     <= 1'b0;
    end else begin
      if (send) begin
        slot_state[queue_mem[head]] <= SLOT_WAIT_ACK;
        head <= head + IDX_W'(1);
      end
      if (ack_ok) begin
        slot_state[ack_index] <= SLOT_EMPTY;
      end
      if (nack_accept) begin
        slot_state[nack_index] <= SLOT_PENDING;
      end
      if (accept) begin
        slot_state[free_index] <= SLOT_PENDING;
      end
      if (push) begin
        tail <= tail + IDX_W'(1);
      end

      case ({push, send})
        2'b10:   q_count <= q_count + CNT_W'(1);
        2'b01:   q_count <= q_count - CNT_W'(1);
        default: q_count <= q_count;
      endcase

      case ({accept, ack_ok})
        2'b10:   outstanding_count <= outstanding_count + CNT_W'(1);
        2'b01:   outstanding_count <= outstanding_count - CNT_W'(1);
        default: outstanding_count <= outstanding_count;
      endcase

      return_index_valid <= ack_ok;
      if (ack_ok) begin
        return_index <= ack_index;
      end
      protocol_error <= protocol_error | ack_err | nack_err | accept_err;
    end
  end

  // Payload and queue storage need no reset; contents are only read when valid.
  always_ff @(posedge nocclk) begin
    if (accept) begin
      payload[free_index] <= in_data;
    end
    if (push) begin
      queue_mem[tail] <= push_idx;
    end
  end

endmodule

// File: tb/tb_packet_slot_tracker.sv
// Directed scenarios plus randomized traffic against a queue-based slot model.
module tb_packet_slot_tracker;

  logic        nocclk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        free_index_valid;
  logic [2:0]  free_index;
  logic        free_index_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  out_index;
  logic        ack_valid;
  logic [2:0]  ack_index;
  logic        nack_valid;
  logic [2:0]  nack_index;
  logic        return_index_valid;
  logic [2:0]  return_index;
  logic [3:0]  outstanding_count;
  logic        protocol_error;

  int checks   = 0;
  int failures = 0;

  // Reference model: slot states 0=empty 1=pending 2=wait-ack.
  int          m_st [8];
  logic [63:0] m_data [8];
  int          m_q [$];
  int          free_q [$];
  int          m_out;
  bit          m_err;
  bit          m_rv;
  int          m_ri;

  packet_slot_tracker #(.NUM_ENTRIES(8), .DATA_WIDTH(64)) dut (
    .nocclk(nocclk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .free_index_valid(free_index_valid), .free_index(free_index),
    .free_index_ready(free_index_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .ack_valid(ack_valid), .ack_index(ack_index),
    .nack_valid(nack_valid), .nack_index(nack_index),
    .return_index_valid(return_index_valid), .return_index(return_index),
    .outstanding_count(outstanding_count), .protocol_error(protocol_error)
  );

  always #5 nocclk = ~nocclk;

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; free_index_valid = 1'b1; free_index = '0;
    out_ready = 1'b0; ack_valid = 1'b0; ack_index = '0; nack_valid = 1'b0; nack_index = '0;
  endtask

  task automatic apply_reset();
    @(negedge nocclk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge nocclk);
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_st[i] = 0; m_data[i] = '0; end
    m_q = {}; m_out = 0; m_err = 0; m_rv = 0; m_ri = 0;
  endtask

  function automatic bit model_nack_accept();
    return nack_valid && (m_st[nack_index] == 2) && !(ack_valid && ack_index == nack_index);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step(output bit acc);
    bit nacc, aok, same;
    int s;
    same = ack_valid && (ack_index == nack_index);
    nacc = model_nack_accept();
    aok  = ack_valid && (m_st[ack_index] == 2);
    acc  = in_valid && free_index_valid && !nacc;
    if (ack_valid && !aok) m_err = 1;
    if (nack_valid && !same && m_st[nack_index] != 2) m_err = 1;
    if (acc && m_st[free_index] != 0) m_err = 1;
    if (m_q.size() > 0 && out_ready) begin
      s = m_q.pop_front();
      m_st[s] = 2;
    end
    m_rv = aok;
    if (aok) begin m_st[ack_index] = 0; m_ri = int'(ack_index); end
    if (nacc) begin m_st[nack_index] = 1; m_q.push_back(int'(nack_index)); end
    if (acc) begin
      m_st[free_index] = 1;
      m_data[free_index] = in_data;
      m_q.push_back(int'(free_index));
    end
    m_out = m_out + int'(acc) - int'(aok);
  endtask

  task automatic test_reset();
    @(negedge nocclk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge nocclk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (return_index_valid !== 1'b0) begin failures++; $display("FAIL reset_ret_valid got=%0b exp=0", return_index_valid); end
    checks++; if (return_index !== 3'd0) begin failures++; $display("FAIL reset_ret_index got=%0d exp=0", return_index); end
    checks++; if (outstanding_count !== 4'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_count); end
    checks++; if (protocol_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0b exp=0", protocol_error); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_hi got=%0b exp=1", in_ready); end
    free_index_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_lo got=%0b exp=0", in_ready); end
    @(negedge nocclk);
    free_index_valid = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_accept_send();
    for (int i = 0; i < 3; i++) begin
      @(negedge nocclk);
      in_valid = 1'b1; free_index_valid = 1'b1; free_index = 3'(i);
      in_data = 64'hA0 + 64'(i); out_ready = 1'b1;
      #1;
      checks++; if (free_index_ready !== 1'b1) begin failures++; $display("FAIL accept_pop i=%0d got=%0b exp=1", i, free_index_ready); end
      @(posedge nocclk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL send_valid i=%0d got=%0b exp=1", i, out_valid); end
      checks++; if (out_index !== 3'(i)) begin failures++; $display("FAIL send_index got=%0d exp=%0d", out_index, i); end
      checks++; if (out_data !== 64'hA0 + 64'(i)) begin failures++; $display("FAIL send_data got=%h exp=%h", out_data, 64'hA0 + 64'(i)); end
    end
    @(negedge nocclk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge nocclk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL send_drained got=%0b exp=0", out_valid); end
    checks++; if (outstanding_count !== 4'd3) begin failures++; $display("FAIL accept_outstanding got=%0d exp=3", outstanding_count); end
  endtask

  task automatic test_ack();
    @(negedge nocclk);
    idle_inputs();
    ack_valid = 1'b1; ack_index = 3'd1;
    @(posedge nocclk); #1;
    checks++; if (return_index_valid !== 1'b1) begin failures++; $display("FAIL ack_pulse got=%0b exp=1", return_index_valid); end
    checks++; if (return_index !== 3'd1) begin failures++; $display("FAIL ack_index got=%0d exp=1", return_index); end
    checks++; if (outstanding_count !== 4'd2) begin failures++; $display("FAIL ack_outstanding got=%0d exp=2", outstanding_count); end
    @(negedge nocclk);
    ack_valid = 1'b0;
    @(posedge nocclk); #1;
    checks++; if (return_index_valid !== 1'b0) begin failures++; $display("FAIL ack_pulse_end got=%0b exp=0", return_index_valid); end
  endtask

  task automatic test_nack();
    @(negedge nocclk);
    idle_inputs();
    nack_valid = 1'b1; nack_index = 3'd2;
    in_valid = 1'b1; free_index_valid = 1'b1; free_index = 3'd1; in_data = 64'hDEAD;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL nack_in_ready got=%0b exp=0", in_ready); end
    checks++; if (free_index_ready !== 1'b0) begin failures++; $display("FAIL nack_pop got=%0b exp=0", free_index_ready); end
    @(posedge nocclk); #1;
    checks++; if (out_valid !== 1'b1 || out_index !== 3'd2) begin failures++; $display("FAIL nack_requeue got=%0b/%0d exp=1/2", out_valid, out_index); end
    checks++; if (out_data !== 64'hA2) begin failures++; $display("FAIL nack_payload got=%h exp=a2", out_data); end
    checks++; if (outstanding_count !== 4'd2) begin failures++; $display("FAIL nack_outstanding got=%0d exp=2", outstanding_count); end
    checks++; if (protocol_error !== 1'b0) begin failures++; $display("FAIL nack_error got=%0b exp=0", protocol_error); end
    @(negedge nocclk);
    idle_inputs();
    out_ready = 1'b1;
    @(negedge nocclk);
    out_ready = 1'b0; ack_valid = 1'b1; ack_index = 3'd0;
    @(negedge nocclk);
    ack_index = 3'd2;
    @(negedge nocclk);
    ack_valid = 1'b0;
    #1;
    checks++; if (outstanding_count !== 4'd0) begin failures++; $display("FAIL nack_cleanup got=%0d exp=0", outstanding_count); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      @(negedge nocclk);
      in_valid = 1'b1; free_index_valid = 1'b1; free_index = 3'((i + 3) % 8);
      in_data = 64'hB0 + 64'(i); out_ready = 1'b0;
    end
    @(negedge nocclk);
    free_index_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || free_index_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b/%0b exp=0/0", in_ready, free_index_ready); end
    checks++; if (outstanding_count !== 4'd8) begin failures++; $display("FAIL full_outstanding got=%0d exp=8", outstanding_count); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'((i + 3) % 8) || out_data !== 64'hB0 + 64'(i)) begin
        failures++;
        $display("FAIL drain_order i=%0d got=%0b/%0d/%h exp=1/%0d/%h", i, out_valid, out_index, out_data, (i + 3) % 8, 64'hB0 + 64'(i));
      end
      @(negedge nocclk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", out_valid); end
    out_ready = 1'b0; free_index_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ack_valid = 1'b1; ack_index = 3'(i);
      @(negedge nocclk);
    end
    ack_valid = 1'b0;
    #1;
    checks++; if (outstanding_count !== 4'd0 || protocol_error !== 1'b0) begin failures++; $display("FAIL drain_release got=%0d/%0b exp=0/0", outstanding_count, protocol_error); end
  endtask

  task automatic test_errors();
    @(negedge nocclk);
    idle_inputs();
    ack_valid = 1'b1; ack_index = 3'd3;
    @(posedge nocclk); #1;
    checks++; if (return_index_valid !== 1'b0) begin failures++; $display("FAIL err_ack_pulse got=%0b exp=0", return_index_valid); end
    checks++; if (protocol_error !== 1'b1) begin failures++; $display("FAIL err_ack_flag got=%0b exp=1", protocol_error); end
    @(negedge nocclk);
    ack_valid = 1'b0; in_valid = 1'b1; free_index = 3'd4; in_data = 64'hC4;
    @(negedge nocclk);
    in_valid = 1'b0; nack_valid = 1'b1; nack_index = 3'd4;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL err_nack_in_ready got=%0b exp=1", in_ready); end
    @(negedge nocclk);
    nack_valid = 1'b0; out_ready = 1'b1;
    @(negedge nocclk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL err_nack_no_requeue got=%0b exp=0", out_valid); end
    checks++; if (outstanding_count !== 4'd1) begin failures++; $display("FAIL err_outstanding got=%0d exp=1", outstanding_count); end
    out_ready = 1'b0;
    repeat (3) @(negedge nocclk);
    #1;
    checks++; if (protocol_error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", protocol_error); end
    apply_reset();
    #1;
    checks++; if (protocol_error !== 1'b0) begin failures++; $display("FAIL err_cleared got=%0b exp=0", protocol_error); end
  endtask

  task automatic test_same_index();
    @(negedge nocclk);
    idle_inputs();
    in_valid = 1'b1; free_index = 3'd5; in_data = 64'hC5;
    @(negedge nocclk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge nocclk);
    out_ready = 1'b0; ack_valid = 1'b1; ack_index = 3'd5; nack_valid = 1'b1; nack_index = 3'd5;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL same_in_ready got=%0b exp=1", in_ready); end
    @(posedge nocclk); #1;
    checks++; if (return_index_valid !== 1'b1 || return_index !== 3'd5) begin failures++; $display("FAIL same_release got=%0b/%0d exp=1/5", return_index_valid, return_index); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL same_no_requeue got=%0b exp=0", out_valid); end
    checks++; if (protocol_error !== 1'b0) begin failures++; $display("FAIL same_error got=%0b exp=0", protocol_error); end
    @(negedge nocclk);
    ack_valid = 1'b0; nack_valid = 1'b0;
    @(posedge nocclk); #1;
    checks++; if (return_index_valid !== 1'b0 || outstanding_count !== 4'd0) begin failures++; $display("FAIL same_once got=%0b/%0d exp=0/0", return_index_valid, outstanding_count); end
  endtask

  task automatic test_reset_mid();
    @(negedge nocclk);
    idle_inputs();
    in_valid = 1'b1; free_index = 3'd1; in_data = 64'hD1;
    @(negedge nocclk);
    free_index = 3'd0; in_data = 64'hD0; out_ready = 1'b1;
    @(negedge nocclk);
    in_valid = 1'b0; out_ready = 1'b0;
    ack_valid = 1'b1; ack_index = 3'd1; nack_valid = 1'b1; nack_index = 3'd7;
    @(posedge nocclk); #1;
    checks++; if (return_index_valid !== 1'b1 || protocol_error !== 1'b1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL midrst_pre got=%0b/%0b/%0b exp=1/1/1", return_index_valid, protocol_error, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (return_index_valid !== 1'b0 || return_index !== 3'd0) begin failures++; $display("FAIL midrst_ret got=%0b/%0d exp=0/0", return_index_valid, return_index); end
    checks++; if (outstanding_count !== 4'd0 || protocol_error !== 1'b0) begin failures++; $display("FAIL midrst_status got=%0d/%0b exp=0/0", outstanding_count, protocol_error); end
    @(negedge nocclk);
    idle_inputs();
    @(negedge nocclk);
    rst_n = 1'b1;
  endtask

  task automatic test_random(input int n);
    int waits [$];
    bit acc, e_nacc;
    apply_reset();
    model_reset();
    free_q = {};
    for (int i = 0; i < 8; i++) free_q.push_back(i);
    for (int c = 0; c < n; c++) begin
      @(negedge nocclk);
      waits = {};
      for (int i = 0; i < 8; i++) if (m_st[i] == 2) waits.push_back(i);
      in_valid = ($urandom_range(0, 9) < 6);
      in_data = {$urandom, $urandom};
      free_index_valid = (free_q.size() > 0) && ($urandom_range(0, 9) != 0);
      free_index = (free_q.size() > 0) ? 3'(free_q[0]) : 3'($urandom_range(0, 7));
      out_ready = 1'($urandom_range(0, 1));
      ack_valid = (waits.size() > 0) && ($urandom_range(0, 9) < 3);
      ack_index = ack_valid ? 3'(waits[$urandom_range(0, waits.size() - 1)]) : 3'($urandom_range(0, 7));
      nack_valid = (waits.size() > 0) && ($urandom_range(0, 9) < 3);
      nack_index = nack_valid ? 3'(waits[$urandom_range(0, waits.size() - 1)]) : 3'($urandom_range(0, 7));
      if (ack_valid && $urandom_range(0, 4) == 0) begin nack_valid = 1'b1; nack_index = ack_index; end
      if ($urandom_range(0, 99) == 0) begin nack_valid = 1'b1; nack_index = 3'($urandom_range(0, 7)); end
      #1;
      e_nacc = model_nack_accept();
      checks++; if (in_ready !== (free_index_valid && !e_nacc)) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%0b exp=%0b", c, in_ready, free_index_valid && !e_nacc); end
      checks++; if (free_index_ready !== (in_valid && free_index_valid && !e_nacc)) begin failures++; $display("FAIL rnd_pop c=%0d got=%0b", c, free_index_ready); end
      checks++; if (out_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL rnd_out_valid c=%0d got=%0b exp=%0b", c, out_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        checks++;
        if (out_index !== 3'(m_q[0]) || out_data !== m_data[m_q[0]]) begin
          failures++; $display("FAIL rnd_out c=%0d got=%0d/%h exp=%0d/%h", c, out_index, out_data, m_q[0], m_data[m_q[0]]);
        end
      end
      @(posedge nocclk);
      model_step(acc);
      if (acc) void'(free_q.pop_front());
      #1;
      checks++; if (return_index_valid !== m_rv) begin failures++; $display("FAIL rnd_ret_valid c=%0d got=%0b exp=%0b", c, return_index_valid, m_rv); end
      if (m_rv) begin
        checks++; if (return_index !== 3'(m_ri)) begin failures++; $display("FAIL rnd_ret_index c=%0d got=%0d exp=%0d", c, return_index, m_ri); end
        free_q.push_back(m_ri);
      end
      checks++; if (outstanding_count !== 4'(m_out)) begin failures++; $display("FAIL rnd_outstanding c=%0d got=%0d exp=%0d", c, outstanding_count, m_out); end
      checks++; if (protocol_error !== m_err) begin failures++; $display("FAIL rnd_error c=%0d got=%0b exp=%0b", c, protocol_error, m_err); end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_accept_send();
    test_ack();
    test_nack();
    test_fill_drain();
    test_errors();
    test_same_index();
    test_reset_mid();
    test_random(1500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
